// File: rtl/udp_arb_pkg.sv
// ----------------------------------------------------------------------------
// udp_arb_pkg: state encoding and protocol constants for udp_tx_arbiter.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package udp_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } arb_state_t;

  localparam int MII_IFG_CYCLES  = 24;
  localparam int UDP_MAX_PAYLOAD = 1472;

  function automatic logic [15:0] clamp_len(input logic [15:0] len,
                                            input logic [15:0] max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

`default_nettype wire

// File: rtl/udp_tx_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick: combinational round-robin selector, scans from last+1 upward.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rr_pick #(
  parameter int N_REQ = 4,
  parameter int LW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [LW-1:0]    last,
  output logic [N_REQ-1:0] winner,
  output logic             any
);

  logic [LW-1:0] idx;
  logic          found;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = LW'((int'(last) + k) % N_REQ);
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

`default_nettype wire

// File: rtl/udp_tx_arbiter.sv
// ----------------------------------------------------------------------------
// udp_tx_arbiter: round-robin scheduler for one UDP TX engine with IFG spacing.
// Define UDP_ARB_TIMEOUT_EN to add a WAIT_DONE watchdog driving tx_abort. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module udp_tx_arbiter
  import udp_arb_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int IFG_CYCLES     = MII_IFG_CYCLES,
  parameter int MAX_LEN        = UDP_MAX_PAYLOAD,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic               mii_tx_clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [16*N_REQ-1:0] req_len,
  input  logic [16*N_REQ-1:0] req_port,
  output logic [N_REQ-1:0]   grant,
  output logic [N_REQ-1:0]   ack,
  output logic               tx_start,
  output logic [15:0]        tx_len,
  output logic [15:0]        tx_dst_port,
  input  logic               tx_done,
  output logic               tx_abort
);

  localparam int LW = $clog2(N_REQ);
  localparam int GW = $clog2(IFG_CYCLES + 1);

  arb_state_t       state;
  logic [LW-1:0]    last;
  logic [LW-1:0]    win_idx;
  logic [N_REQ-1:0] winner;
  logic [N_REQ-1:0] arb_req;
  logic             any;
  logic [15:0]      sel_len;
  logic [15:0]      sel_port;
  logic [GW-1:0]    gap_cnt;
  logic             zero_len;

  // The requester just acked is masked so a zero-length frame cannot re-win
  // before its owner has had a cycle to drop req.
  assign arb_req = req & ~ack;

  rr_pick #(.N_REQ(N_REQ), .LW(LW)) u_rr_pick (
    .req    (arb_req),
    .last   (last),
    .winner (winner),
    .any    (any)
  );

  always_comb begin
    win_idx  = '0;
    sel_len  = '0;
    sel_port = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (winner[i]) begin
        win_idx  = LW'(i);
        sel_len  = req_len[16*i +: 16];
        sel_port = req_port[16*i +: 16];
      end
    end
  end

`ifdef UDP_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tout_cnt;
`else
  assign tx_abort = 1'b0;
`endif

  always_ff @(posedge mii_tx_clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= '0;
      ack         <= '0;
      tx_start    <= 1'b0;
      tx_len      <= '0;
      tx_dst_port <= '0;
      last        <= LW'(N_REQ - 1);
      gap_cnt     <= '0;
      zero_len    <= 1'b0;
`ifdef UDP_ARB_TIMEOUT_EN
      tout_cnt    <= '0;
      tx_abort    <= 1'b0;
`endif
    end else begin
      tx_start <= 1'b0;
      ack      <= '0;
`ifdef UDP_ARB_TIMEOUT_EN
      tx_abort <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (any) begin
            grant       <= winner;
            last        <= win_idx;
            tx_len      <= clamp_len(sel_len, 16'(MAX_LEN));
            tx_dst_port <= sel_port;
            zero_len    <= (sel_len == 16'd0);
            tx_start    <= (sel_len != 16'd0);
            state       <= START;
`ifdef UDP_ARB_TIMEOUT_EN
            tout_cnt    <= '0;
`endif
          end
        end
        START: begin
          // Zero-length frames never reach the engine: ack straight away, no gap.
          if (zero_len) begin
            ack   <= grant;
            grant <= '0;
            state <= IDLE;
          end else begin
            state <= WAIT_DONE;
          end
`ifdef UDP_ARB_TIMEOUT_EN
          tout_cnt <= tout_cnt + 1'b1;
`endif
        end
        WAIT_DONE: begin
          if (tx_done) begin
            ack     <= grant;
            grant   <= '0;
            gap_cnt <= '0;
            state   <= GAP;
          end
`ifdef UDP_ARB_TIMEOUT_EN
          else if (tout_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            tx_abort <= 1'b1;
            ack      <= grant;
            grant    <= '0;
            gap_cnt  <= '0;
            state    <= GAP;
          end else begin
            tout_cnt <= tout_cnt + 1'b1;
          end
`endif
        end
        GAP: begin
          if (gap_cnt == GW'(IFG_CYCLES - 1)) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
